// File: rtl/load_store_unit.sv
// load_store_unit: single-transaction memory-stage LSU with lane steering, timeout and load extraction.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
  state_t state, state_n;
  logic [2:0] op;
  logic [1:0] a, a_req;
  logic [4:0] rd;
  logic [7:0] cnt;
  logic [31:0] data, wdata_n, ext;
  logic [3:0] be_n;
  logic err, illegal, mis, timeout, accept;
  assign illegal = req_op[1:0] == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (req_op[1:0] == 2'b00 && req_addr[1:0] != 2'b00) || (req_op[1:0] == 2'b10 && req_addr[0]);
  assign a_req = req_addr[1:0];
`else
  assign mis = 1'b0;
  assign a_req = req_op[1:0] == 2'b00 ? 2'b00 : req_op[1:0] == 2'b10 ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
  assign accept = state == IDLE && req_valid;
  assign timeout = cnt == LAST;
  assign be_n = !req_op[2] ? 4'hF :
                req_op[1:0] == 2'b01 ? 4'b0001 << a_req :
                req_op[1:0] == 2'b10 ? (a_req[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign wdata_n = !req_op[2] ? 32'd0 :
                   req_op[1:0] == 2'b01 ? {4{req_wdata[7:0]}} :
                   req_op[1:0] == 2'b10 ? {2{req_wdata[15:0]}} : req_wdata;
  assign ext = op[1:0] == 2'b01 ? {24'd0, bus_rdata[{a, 3'b000} +: 8]} :
               op[1:0] == 2'b10 ? {16'd0, bus_rdata[{a[1], 4'b0000} +: 16]} : bus_rdata;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = req_valid ? ((illegal || mis) ? RESP : BUS) : IDLE;
      BUS:  state_n = (bus_ack || timeout) ? RESP : BUS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= 3'd0;
      a         <= 2'd0;
      rd        <= 5'd0;
      cnt       <= 8'd0;
      data      <= 32'd0;
      err       <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        op        <= req_op;
        a         <= a_req;
        rd        <= req_rd;
        cnt       <= 8'd0;
        data      <= 32'd0;
        err       <= illegal || mis;
        bus_we    <= req_op[2];
        bus_addr  <= {req_addr[31:2], 2'b00};
        bus_be    <= be_n;
        bus_wdata <= wdata_n;
      end
      if (state == BUS) begin
        cnt <= cnt + 8'd1;
        if (bus_ack) data <= op[2] ? 32'd0 : ext;
        else if (timeout) err <= 1'b1;
      end
    end
  end
  assign req_ready = state == IDLE && !rst;
  assign bus_req   = state == BUS;
  assign rsp_valid = state == RESP;
  assign rsp_err   = rsp_valid && err;
  assign rsp_we    = rsp_valid && !op[2] && !err && rd != 5'd0;
  assign rsp_rd    = rd;
  assign rsp_rdata = data;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checking of load_store_unit against a byte-level model.
module tb_load_store_unit;
  localparam int MW = 4;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [2:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [4:0] req_rd = 0;
  logic bus_req, bus_we, bus_ack = 0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic [3:0] bus_be;
  logic rsp_valid, rsp_we, rsp_err;
  logic [4:0] rsp_rd;
  logic [31:0] rsp_rdata;
  int checks = 0, errors = 0;
  logic exp_err, exp_bus, exp_we_bus, exp_rsp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0] exp_be;
  logic [4:0] exp_rd;
  int exp_lat, exp_nbus;
  logic last_bus_we, last_rsp_we, last_rsp_err;
  logic [31:0] last_bus_addr, last_bus_wdata, last_rsp_rdata;
  logic [3:0] last_bus_be;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected behaviour from access size and byte offset; delay is the 0-based BUS cycle of the ack.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, wdata, rdata, input logic [4:0] rd, input int delay);
    int size, a;
    logic [31:0] v;
    logic load;
    load = !op[2];
    size = op[1:0] == 2'b00 ? 4 : op[1:0] == 2'b01 ? 1 : 2;
    a = int'(addr[1:0]);
    exp_err = op[1:0] == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % size != 0) exp_err = 1;
`else
    a = a - a % size;
`endif
    exp_bus = !exp_err;
    if (exp_bus && delay >= MW) exp_err = 1;
    exp_lat = !exp_bus ? 1 : (delay < MW ? delay : MW - 1) + 2;
    exp_nbus = !exp_bus ? 0 : (delay < MW ? delay : MW - 1) + 1;
    exp_addr = addr & ~32'd3;
    exp_we_bus = op[2];
    exp_be = load ? 4'hF : 4'(((1 << size) - 1) << a);
    exp_wdata = 0;
    if (!load) for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    v = rdata >> (8 * a);
    if (size < 4) v = v & ((32'd1 << (8 * size)) - 1);
    exp_rdata = (load && !exp_err) ? v : 32'd0;
    exp_rsp_we = load && !exp_err && rd != 0;
    exp_rd = rd;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        chk("bus_we", bus_we, exp_we_bus);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_be", bus_be, exp_be);
        chk("bus_wdata", bus_wdata, exp_wdata);
        last_bus_we = bus_we; last_bus_addr = bus_addr; last_bus_be = bus_be; last_bus_wdata = bus_wdata;
      end
      if (rsp_valid) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_we", rsp_we, exp_rsp_we);
        chk("rsp_rd", rsp_rd, exp_rd);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        last_rsp_we = rsp_we; last_rsp_err = rsp_err; last_rsp_rdata = rsp_rdata;
      end
    end
  end

  // Called just after a falling edge while the LSU should be idle.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, wdata, input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    int nbus;
    bit done;
    model(op, addr, wdata, rdata, rd, delay);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    nbus = 0; done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("latency", k, exp_lat);
        chk("bus_cycles", nbus, exp_nbus);
        bus_ack = 1'($urandom);
        done = 1;
      end else if (bus_req) begin
        bus_ack = nbus == delay;
        bus_rdata = bus_ack ? rdata : $urandom;
        nbus++;
      end else begin
        bus_ack = 1'($urandom);
        bus_rdata = $urandom;
      end
    end
    if (!done) chk("rsp_arrived", 0, 1);
    @(negedge clk);
    bus_ack = 0;
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3, 3'd7};
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_bus_req", bus_req, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_bus_be", bus_be, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("ready_after_release", req_ready, 1);
    do_txn(3'd1, 32'h1003, 32'h0, 5'd5, 0, 32'hAABBCCDD);
    chk("lbu_be", last_bus_be, 4'hF);
    chk("lbu_addr", last_bus_addr, 32'h1000);
    chk("lbu_rdata", last_rsp_rdata, 32'h000000AA);
    chk("lbu_we", last_rsp_we, 1);
    do_txn(3'd6, 32'h2002, 32'h12345678, 5'd3, 0, 32'h0);
    chk("sh_we", last_bus_we, 1);
    chk("sh_be", last_bus_be, 4'b1100);
    chk("sh_wdata", last_bus_wdata, 32'h56785678);
    chk("sh_rsp_we", last_rsp_we, 0);
    chk("sh_err", last_rsp_err, 0);
    do_txn(3'd0, 32'h100, 32'h0, 5'd7, 99, 32'h0);
    chk("timeout_err", last_rsp_err, 1);
    chk("timeout_we", last_rsp_we, 0);
    do_txn(3'd0, 32'h104, 32'h0, 5'd7, MW - 1, 32'hCAFEF00D);
    chk("late_ack_err", last_rsp_err, 0);
    chk("late_ack_data", last_rsp_rdata, 32'hCAFEF00D);
    do_txn(3'd0, 32'h3001, 32'h0, 5'd9, 0, 32'h01020304);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lw_err", last_rsp_err, 1);
`else
    chk("mis_lw_addr", last_bus_addr, 32'h3000);
    chk("mis_lw_data", last_rsp_rdata, 32'h01020304);
`endif
    do_txn(3'd3, 32'h40, 32'h0, 5'd4, 0, 32'h0);
    chk("illegal_err", last_rsp_err, 1);
    do_txn(3'd0, 32'h44, 32'h0, 5'd0, 0, 32'h55);
    chk("rd0_we", last_rsp_we, 0);
    model(3'd0, 32'h80, 32'h0, 32'h0, 5'd7, 99);
    req_valid = 1; req_op = 3'd0; req_addr = 32'h80; req_rd = 5'd7;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_bus_req", bus_req, 1);
    #2 rst = 1;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("post_rst_ready", req_ready, 1);
    chk("post_rst_rsp", rsp_valid, 0);
    do_txn(3'd5, 32'h11, 32'hA5, 5'd2, 0, 32'h0);
    chk("sb_be", last_bus_be, 4'b0010);
    chk("sb_wdata", last_bus_wdata, 32'hA5A5A5A5);
    for (int n = 0; n < 300; n++)
      do_txn(ops[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             $urandom_range(0, MW + 1), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU's ADD result as the effective address for lw/lbu/lhu/sw/sb/sh and runs one word-wide bus transaction per instruction: byte-lane steering, byte enables, wait for acknowledge, timeout, and load-data extraction. It returns a one-cycle writeback response to the register-file write port.

## Interface
Parameters:
- MAX_WAIT, 255: bus cycles to wait for bus_ack before aborting with error; legal range 1..255.

Ports (one clock domain; reset is asynchronous, active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU idle and accepting
- req_op  in  3  000 LW, 001 LBU, 010 LHU, 100 SW, 101 SB, 110 SH; 011/111 illegal
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rt), unshifted
- req_rd  in  5  load destination register
- bus_req  out  1  transaction request, held until ack or timeout
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables, little-endian lanes
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle completion strobe
- bus_rdata  in  32  read data, valid with bus_ack
- rsp_valid  out  1  one-cycle response pulse
- rsp_we  out  1  write rsp_rdata to rsp_rd
- rsp_rd  out  5  destination register
- rsp_rdata  out  32  zero-extended load result
- rsp_err  out  1  misalign / illegal op / timeout

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, capture op, address, lanes and rd.
  - Illegal op -> RESP with err; no bus access.
  - Otherwise -> BUS.
- BUS: bus_req=1 with stable bus_we/addr/be/wdata.
  - On bus_ack: capture the extracted read data -> RESP.
  - When the wait counter reaches MAX_WAIT without an ack: err -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Lanes, where a = addr[1:0]:
  - SW: be=1111, wdata=req_wdata.
  - SH: be = a[1] ? 1100 : 0011, wdata={2{wdata[15:0]}}.
  - SB: be = 0001<<a, wdata={4{wdata[7:0]}}.
  - Loads: be=1111, bus_wdata=0.
- Extraction:
  - LW: rdata.
  - LHU: zero-extended rdata[16*a[1] +: 16].
  - LBU: zero-extended rdata[8*a +: 8].
- rsp_we = load && !rsp_err && rsp_rd!=0.
- rsp_rdata=0 for stores and on error.
- rsp_rd echoes the captured req_rd in all cases.

## Timing
- Request accepted at edge N.
- bus_req is high in cycle N+1.
- If bus_ack is high at edge M, rsp_valid is high in cycle M+1, and req_ready returns high in cycle M+2.
- Minimum latency, with ack in the first BUS cycle: accept -> rsp_valid in 2 cycles, 3-cycle issue interval.
- Timeout: the counter clears on entry to BUS and increments each BUS cycle without ack. Error is flagged on the MAX_WAIT-th ackless cycle, and bus_req drops at the next edge.
  - An ack in that same cycle wins: normal completion, no error.
- Illegal or misaligned op: rsp_valid in cycle N+1; no bus_req ever asserted.
- bus_ack outside BUS is ignored.
- req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Reset, including mid-transaction:
  - Immediately forces IDLE, with bus_req=0, rsp_valid=0, rsp_we=0, rsp_err=0, and all data/addr/be outputs 0.
  - req_ready=0 while rst is high and 1 in the first cycle after release.
  - The counter is cleared.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LW with a!=00, or LHU/SH with a[0]=1, completes in RESP with rsp_err=1.
  - No bus access; rsp_we=0.
- Not defined:
  - Low address bits are force-aligned: word ops use a=00, halfword ops clear a[0].
  - The access proceeds normally; rsp_err only flags illegal op or timeout.

## Test plan
- LBU addr 0x1003, bus_rdata 0xAABBCCDD, ack 1st BUS cycle -> bus_be=1111, bus_addr=0x1000, rsp_rdata=0x000000AA, rsp_we=1, rsp_valid exactly 2 cycles after accept.
- SH addr 0x2002, req_wdata 0x12345678 -> bus_we=1, bus_be=1100, bus_wdata=0x56785678, rsp_we=0, rsp_err=0.
- LW with ack withheld, MAX_WAIT=4 -> bus_req high 4 cycles then low, rsp_err=1, rsp_we=0; ack on 4th cycle instead -> no error.
- LW addr 0x3001: with LSU_MISALIGN_TRAP_EN, rsp_err=1 and no bus_req; without it, bus_addr=0x3000 and normal data returned.
- Assert rst while in BUS with bus_req high -> bus_req low immediately, no rsp_valid; after release, req_ready=1 and a new SB addr 0x11 gives be=0010.
- req_op=011 -> rsp_err=1, rsp_valid in cycle N+1, no bus_req; req_rd=0 load -> rsp_we=0.
